cla_sub_pipe: RTL and testbench

//  - Pipelined two-stage carry-look-ahead subtractor: diff = in1 - in2 - borrow_in (mod 2^data).
//  - Inverse of the CLA adder: computes in1 + ~in2 + ~borrow_in using generate/propagate carry logic.
//  - Lower half resolves in stage 1 and upper half in stage 2, so the adder chain is cut mid-word.
//  - valid/ready on both sides; sits between operand sources and the ALU result bus.

---
 rtl/cla_sub_pipe.sv | 214 +++++++++++++++++++++
 tb/tb_cla_sub_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_sub_pipe.sv
// cla_sub_pipe: two-stage pipelined carry-look-ahead subtractor.
//   diff = in1 - in2 - borrow_in (mod 2^data), computed as in1 + ~in2 + ~borrow_in.
//   Stage 1 resolves the low data/2 bits and the carry into the upper half;
//   stage 2 resolves the upper data - data/2 bits and the final borrow.
// Optional feature macro: CLA_SUB_OVF_EN
//   defined   -> overflow flags signed overflow, registered alongside diff,
//                using operand sign bits captured in stage 1.
//   undefined -> overflow is tied to 0 and no sign registers exist.
//
// Handshake (both sides): a beat transfers on a rising clk edge where
// valid & ready are both 1. in_ready = ~s1_valid | s2_load, so it depends
// combinationally on out_ready (no skid buffer). A producer may hold in_valid
// high while in_ready is 0; nothing is captured until both are 1. Once
// out_valid is 1, diff/borrow_out/overflow stay frozen until out_ready is 1.
module cla_sub_pipe #(
    parameter int data = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [data-1:0] in1,
    input  logic [data-1:0] in2,
    input  logic            borrow_in,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [data-1:0] diff,
    output logic            borrow_out,
    output logic            overflow,
    output logic            out_valid,
    input  logic            out_ready
);

    // Split of the word: low half is resolved in stage 1, high half in stage 2.
    localparam int LO     = data / 2;
    localparam int HI     = data - LO;
    // Each half is evaluated in 4-bit lookahead groups; widths are padded up.
    localparam int LO_GRP = (LO + 3) / 4;
    localparam int HI_GRP = (HI + 3) / 4;
    localparam int LO_W   = LO_GRP * 4;
    localparam int HI_W   = HI_GRP * 4;

    // Stage 1 registers.
    logic          s1_valid;
    logic [LO-1:0] s1_lo;
    logic          s1_c_mid;
    logic [HI-1:0] s1_a_hi;
    logic [HI-1:0] s1_nb_hi;

    // Stage 2 valid (exported as out_valid).
    logic          s2_valid;

    // Pipeline advance controls.
    logic          s1_load;
    logic          s2_load;

    // Combinational half-word results.
    logic [LO-1:0] lo_sum;
    logic          lo_cout;
    logic [HI-1:0] hi_sum;
    logic          hi_cout;

    // Advance rules: stage 2 accepts when empty or draining; stage 1 accepts on input transfer.
    always_comb begin
        s2_load  = s1_valid & (~s2_valid | out_ready);
        in_ready = ~s1_valid | s2_load;
        s1_load  = in_valid & in_ready;
    end

    assign out_valid = s2_valid;

    // Low-half lookahead sum of in1 + ~in2 with carry-in ~borrow_in.
    // Padding bits propagate (p=1, g=0) so they never disturb the group carry.
    always_comb begin
        logic [LO_W-1:0] g;
        logic [LO_W-1:0] p;
        logic [LO_W-1:0] s;
        logic            gg;
        logic            gp;
        logic            c;
        logic            cb;
        g  = '0;
        p  = '1;
        s  = '0;
        gg = 1'b0;
        gp = 1'b1;
        cb = 1'b0;
        g[LO-1:0] = in1[LO-1:0] & ~in2[LO-1:0];
        p[LO-1:0] = in1[LO-1:0] ^ ~in2[LO-1:0];
        c = ~borrow_in;
        for (int k = 0; k < LO_GRP; k++) begin
            // Group generate/propagate.
            gg = 1'b0;
            gp = 1'b1;
            for (int j = 0; j < 4; j++) begin
                gg = g[4*k+j] | (p[4*k+j] & gg);
                gp = gp & p[4*k+j];
            end
            // Bit sums inside the group from the group's carry-in.
            cb = c;
            for (int j = 0; j < 4; j++) begin
                s[4*k+j] = p[4*k+j] ^ cb;
                cb       = g[4*k+j] | (p[4*k+j] & cb);
            end
            // Group carry-out from lookahead terms.
            c = gg | (gp & c);
        end
        lo_sum  = s[LO-1:0];
        lo_cout = c;
    end

    // High-half lookahead sum of captured in1 / ~in2 upper bits with carry-in c_mid.
    always_comb begin
        logic [HI_W-1:0] g;
        logic [HI_W-1:0] p;
        logic [HI_W-1:0] s;
        logic            gg;
        logic            gp;
        logic            c;
        logic            cb;
        g  = '0;
        p  = '1;
        s  = '0;
        gg = 1'b0;
        gp = 1'b1;
        cb = 1'b0;
        g[HI-1:0] = s1_a_hi & s1_nb_hi;
        p[HI-1:0] = s1_a_hi ^ s1_nb_hi;
        c = s1_c_mid;
        for (int k = 0; k < HI_GRP; k++) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int j = 0; j < 4; j++) begin
                gg = g[4*k+j] | (p[4*k+j] & gg);
                gp = gp & p[4*k+j];
            end
            cb = c;
            for (int j = 0; j < 4; j++) begin
                s[4*k+j] = p[4*k+j] ^ cb;
                cb       = g[4*k+j] | (p[4*k+j] & cb);
            end
            c = gg | (gp & c);
        end
        hi_sum  = s[HI-1:0];
        hi_cout = c;
    end

    // Stage 1: capture low-half result, mid carry and upper operand halves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_lo    <= '0;
            s1_c_mid <= 1'b0;
            s1_a_hi  <= '0;
            s1_nb_hi <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_lo    <= lo_sum;
                s1_c_mid <= lo_cout;
                s1_a_hi  <= in1[data-1:LO];
                s1_nb_hi <= ~in2[data-1:LO];
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2: assemble the full difference and the unsigned borrow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_valid   <= 1'b1;
                diff       <= {hi_sum, s1_lo};
                borrow_out <= ~hi_cout;
            end else if (out_valid & out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

`ifdef CLA_SUB_OVF_EN
    logic s1_sign_a;
    logic s1_sign_b;
    logic ovf_q;

    // Operand sign bits travel with stage 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sign_a <= 1'b0;
            s1_sign_b <= 1'b0;
        end else if (s1_load) begin
            s1_sign_a <= in1[data-1];
            s1_sign_b <= in2[data-1];
        end
    end

    // Signed overflow: operand signs differ and the result sign differs from in1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (s2_load) begin
            ovf_q <= (s1_sign_a ^ s1_sign_b) & (hi_sum[HI-1] ^ s1_sign_a);
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Testbench for cla_sub_pipe (data = 32). Reference model is plain wide
// arithmetic; a queue holds expected results in acceptance order.
module tb_cla_sub_pipe;

    localparam int W  = 32;
    localparam int LO = W / 2;

    logic         clk;
    logic         rst;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         borrow_in;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;
    logic         out_valid;
    logic         out_ready;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Scoreboard: {overflow, borrow_out, diff} per accepted op, plus its acceptance cycle.
    logic [W+1:0] exp_q[$];
    int           acc_q[$];

    cla_sub_pipe #(.data(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in1        (in1),
        .in2        (in2),
        .borrow_in  (borrow_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    // Clock / cycle counter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog.
    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // Reference: wide unsigned subtraction; bit W of the wide result is the borrow.
    function automatic logic [W+1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic bi);
        logic [W:0] full;
        logic       ov;
        full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
        ov   = 1'b0;
`ifdef CLA_SUB_OVF_EN
        ov = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
`endif
        return {ov, full[W], full[W-1:0]};
    endfunction

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b1, {(W-1){1'b0}}};
            3:       v = {{(W-LO){1'b0}}, {LO{1'b1}}};
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Driver: apply inputs at the falling edge, let comb settle, report transfers.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bi, input logic ordy,
                        output logic took_in, output logic took_out);
        @(negedge clk);
        in_valid  = v;
        in1       = a;
        in2       = b;
        borrow_in = bi;
        out_ready = ordy;
        #1;
        took_in  = in_valid && in_ready;
        took_out = out_valid && out_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_tests++;
        if (diff !== '0) begin n_fail++; $display("FAIL reset_diff: got %h want 0", diff); end
        n_tests++;
        if (borrow_out !== 1'b0) begin n_fail++; $display("FAIL reset_borrow: got %b want 0", borrow_out); end
        n_tests++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    endtask

    // Directed vectors with exact two-edge latency.
    task automatic test_directed();
        logic [W-1:0] ta[5];
        logic [W-1:0] tb[5];
        logic         tbi[5];
        logic [W-1:0] td[5];
        logic         tbo[5];
        logic         tov[5];
        logic         ti, to;
        ta[0] = 32'd10;         tb[0] = 32'd23; tbi[0] = 1'b0; td[0] = 32'hFFFF_FFF3; tbo[0] = 1'b1;
        ta[1] = 32'h0001_0000;  tb[1] = 32'd1;  tbi[1] = 1'b0; td[1] = 32'h0000_FFFF; tbo[1] = 1'b0;
        ta[2] = 32'd5;          tb[2] = 32'd5;  tbi[2] = 1'b1; td[2] = 32'hFFFF_FFFF; tbo[2] = 1'b1;
        ta[3] = 32'h8000_0000;  tb[3] = 32'd1;  tbi[3] = 1'b0; td[3] = 32'h7FFF_FFFF; tbo[3] = 1'b0;
        ta[4] = 32'd3;          tb[4] = 32'd1;  tbi[4] = 1'b0; td[4] = 32'h0000_0002; tbo[4] = 1'b0;
        for (int i = 0; i < 5; i++) tov[i] = 1'b0;
`ifdef CLA_SUB_OVF_EN
        tov[3] = 1'b1;
`endif
        for (int i = 0; i < 5; i++) begin
            step(1'b1, ta[i], tb[i], tbi[i], 1'b1, ti, to);
            n_tests++;
            if (ti !== 1'b1) begin n_fail++; $display("FAIL dir%0d_accept: in_ready got %b want 1", i, in_ready); end
            step(1'b0, '0, '0, 1'b0, 1'b1, ti, to);
            n_tests++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_early: out_valid got %b want 0", i, out_valid); end
            step(1'b0, '0, '0, 1'b0, 1'b1, ti, to);
            n_tests++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_latency: out_valid got %b want 1", i, out_valid); end
            n_tests++;
            if (diff !== td[i]) begin n_fail++; $display("FAIL dir%0d_diff: got %h want %h", i, diff, td[i]); end
            n_tests++;
            if (borrow_out !== tbo[i]) begin n_fail++; $display("FAIL dir%0d_borrow: got %b want %b", i, borrow_out, tbo[i]); end
            n_tests++;
            if (overflow !== tov[i]) begin n_fail++; $display("FAIL dir%0d_overflow: got %b want %b", i, overflow, tov[i]); end
        end
    endtask

    // Streaming: random handshakes (toggle_mode=0) or continuous input with out_ready 1,0,0 repeating.
    task automatic test_stream(input int n, input logic toggle_mode);
        logic [W-1:0] a, b;
        logic         bi, have, v, ordy, ti, to;
        logic         want_ov, want_ir;
        int           sent, recv, k;
        a = '0; b = '0; bi = 1'b0; have = 1'b0;
        sent = 0; recv = 0; k = 0;
        while (recv < n && k < 4000) begin
            if (!have && sent < n) begin
                a = pick_operand();
                b = pick_operand();
                bi = 1'($urandom_range(0, 1));
                have = 1'b1;
            end
            if (toggle_mode) begin
                v    = have;
                ordy = (k % 3 == 0);
            end else begin
                v    = have && ($urandom_range(0, 3) != 0);
                ordy = ($urandom_range(0, 2) != 0);
            end
            step(v, a, b, bi, ordy, ti, to);
            want_ov = (exp_q.size() != 0) && (cyc - acc_q[0] >= 2);
            want_ir = (exp_q.size() < 2) || ordy;
            n_tests++;
            if (out_valid !== want_ov) begin
                n_fail++; $display("FAIL stream_out_valid k=%0d: got %b want %b", k, out_valid, want_ov);
            end
            n_tests++;
            if (in_ready !== want_ir) begin
                n_fail++; $display("FAIL stream_in_ready k=%0d: got %b want %b", k, in_ready, want_ir);
            end
            if (want_ov) begin
                n_tests++;
                if ({overflow, borrow_out, diff} !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL stream_result k=%0d: got ovf=%b bo=%b diff=%h want ovf=%b bo=%b diff=%h",
                             k, overflow, borrow_out, diff, exp_q[0][W+1], exp_q[0][W], exp_q[0][W-1:0]);
                end
            end
            if (to && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
                recv++;
            end
            if (ti) begin
                exp_q.push_back(ref_sub(a, b, bi));
                acc_q.push_back(cyc);
                have = 1'b0;
                sent++;
            end
            k++;
        end
        n_tests++;
        if (recv != n || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stream_complete: received %0d of %0d, %0d left pending", recv, n, exp_q.size());
        end
    endtask

    // Reset with two ops in flight, then one op afterwards.
    task automatic test_reset_mid_flight();
        logic ti, to;
        step(1'b1, 32'd11, 32'd4, 1'b0, 1'b0, ti, to);
        n_tests++;
        if (ti !== 1'b1) begin n_fail++; $display("FAIL midrst_accept1: got %b want 1", ti); end
        step(1'b1, 32'd20, 32'd30, 1'b1, 1'b0, ti, to);
        n_tests++;
        if (ti !== 1'b1) begin n_fail++; $display("FAIL midrst_accept2: got %b want 1", ti); end
        step(1'b0, '0, '0, 1'b0, 1'b0, ti, to);
        n_tests++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_full: out_valid got %b want 1", out_valid); end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        n_tests++;
        if (diff !== '0) begin n_fail++; $display("FAIL midrst_diff: got %h want 0", diff); end
        n_tests++;
        if (borrow_out !== 1'b0) begin n_fail++; $display("FAIL midrst_borrow: got %b want 0", borrow_out); end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        step(1'b1, 32'd7, 32'd3, 1'b0, 1'b1, ti, to);
        n_tests++;
        if (ti !== 1'b1) begin n_fail++; $display("FAIL postrst_accept: got %b want 1", ti); end
        step(1'b0, '0, '0, 1'b0, 1'b1, ti, to);
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL postrst_stale: out_valid got %b want 0", out_valid); end
        step(1'b0, '0, '0, 1'b0, 1'b1, ti, to);
        n_tests++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL postrst_valid: got %b want 1", out_valid); end
        n_tests++;
        if (diff !== 32'd4 || borrow_out !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL postrst_result: got diff=%h bo=%b ovf=%b want diff=00000004 bo=0 ovf=0",
                     diff, borrow_out, overflow);
        end
    endtask

    // Sequence and final report.
    initial begin
        rst       = 1'b1;
        in1       = '0;
        in2       = '0;
        borrow_in = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_stream(8, 1'b1);
        test_stream(200, 1'b0);
        test_stream(40, 1'b1);
        test_reset_mid_flight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
